// File: rtl/scan_crypt_sched_if.sv
// scan_crypt_sched_if: capture/handoff/drain signals between the scheduler (master) and the SIPO/AES datapath (slave)
//   cap_en     SIPO store enable, one bit per cycle
//   cap_idx    bit position being captured (0 = MSB, bit 127)
//   blk_valid  captured block offered to the AES engine
//   blk_ready  engine accepts the block (transfer when valid & ready)
//   enc_done   engine completion pulse
//   shift_en   ciphertext serial-out enable
interface scan_crypt_sched_if;
    logic       cap_en;
    logic [6:0] cap_idx;
    logic       blk_valid;
    logic       blk_ready;
    logic       enc_done;
    logic       shift_en;
    modport master(output cap_en, cap_idx, blk_valid, shift_en, input blk_ready, enc_done);
    modport slave(input cap_en, cap_idx, blk_valid, shift_en, output blk_ready, enc_done);
endinterface

// File: rtl/scan_crypt_sched.sv
// scan_crypt_sched: sequences capture, AES handoff, encryption wait and drain of one scan block per frame
//   clk, reset   rising-edge clock, synchronous active-high reset
//   start        arms the scheduler from IDLE
//   abort        returns to IDLE on the next cycle from any state
//   continuous   sampled at end of drain: 1 re-arms WAIT, 0 goes IDLE
//   err_clr      clears the sticky timeout error
//   bus          capture/handoff/drain signals (master side)
//   busy         high in every state except IDLE
//   err_timeout  sticky: engine did not complete within ENC_TIMEOUT cycles
//   frame_cnt    completed frames, wraps 255 -> 0
module scan_crypt_sched #(
    parameter int START_DELAY = 289,
    parameter int BLOCK_BITS  = 128,
    parameter int ENC_TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      continuous,
    input  logic                      err_clr,
    scan_crypt_sched_if.master        bus,
    output logic                      busy,
    output logic                      err_timeout,
    output logic [7:0]                frame_cnt
);
    typedef enum logic [2:0] {IDLE, WAIT, CAPTURE, HANDOFF, ENC, DRAIN} state_t;

    state_t      state, nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [6:0]  idx_nxt;
    logic        tmo, frame_done;

    always_comb begin
        nxt        = state;
        cnt_nxt    = cnt + 16'd1;
        idx_nxt    = 7'd0;
        tmo        = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE:    nxt = start ? WAIT : IDLE;
            WAIT:    nxt = (cnt == 16'(START_DELAY - 1)) ? CAPTURE : WAIT;
            CAPTURE: begin
                idx_nxt = bus.cap_idx + 7'd1;
                if (bus.cap_idx == 7'(BLOCK_BITS - 1)) begin
                    nxt     = HANDOFF;
                    idx_nxt = 7'd0;
                end
            end
            HANDOFF: nxt = bus.blk_ready ? ENC : HANDOFF;
            ENC: begin
                // completion on the final allowed cycle still wins over the timeout
                if (bus.enc_done)
                    nxt = DRAIN;
                else if (cnt == 16'(ENC_TIMEOUT - 1)) begin
                    nxt = IDLE;
                    tmo = 1'b1;
                end
            end
            DRAIN: begin
                if (cnt == 16'(BLOCK_BITS - 1)) begin
                    frame_done = 1'b1;
                    nxt        = continuous ? WAIT : IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
        // one shared counter, restarted on every state change
        if (nxt != state)
            cnt_nxt = 16'd0;
        if (abort) begin
            nxt        = IDLE;
            cnt_nxt    = 16'd0;
            idx_nxt    = 7'd0;
            tmo        = 1'b0;
            frame_done = 1'b0;
        end
    end

    // outputs are registered from the next state so they line up with the state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 16'd0;
            bus.cap_idx   <= 7'd0;
            bus.cap_en    <= 1'b0;
            bus.blk_valid <= 1'b0;
            bus.shift_en  <= 1'b0;
            busy          <= 1'b0;
            err_timeout   <= 1'b0;
            frame_cnt     <= 8'd0;
        end else begin
            state         <= nxt;
            cnt           <= cnt_nxt;
            bus.cap_idx   <= idx_nxt;
            bus.cap_en    <= nxt == CAPTURE;
            bus.blk_valid <= nxt == HANDOFF;
            bus.shift_en  <= nxt == DRAIN;
            busy          <= nxt != IDLE;
            err_timeout   <= tmo | (err_timeout & ~err_clr);
            frame_cnt     <= frame_cnt + {7'd0, frame_done};
        end
    end
endmodule

// File: tb/tb_scan_crypt_sched.sv
// tb_scan_crypt_sched: directed checks of scan_crypt_sched timing, handshake, timeout, abort and frame wrap
module tb_scan_crypt_sched;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, abort = 1'b0, continuous = 1'b0, err_clr = 1'b0;
    logic       busy, err_timeout;
    logic [7:0] frame_cnt;
    logic       f_start = 1'b0, f_cont = 1'b0;
    logic       f_busy, f_err;
    logic [7:0] f_frame_cnt;
    int         n_chk = 0, n_fail = 0, viol = 0;

    scan_crypt_sched_if bus();
    scan_crypt_sched_if fbus();

    scan_crypt_sched dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .continuous(continuous),
        .err_clr(err_clr), .bus(bus), .busy(busy), .err_timeout(err_timeout), .frame_cnt(frame_cnt)
    );

    // short-window instance so the 256-frame wrap fits in a small cycle budget
    scan_crypt_sched #(.START_DELAY(2), .BLOCK_BITS(8), .ENC_TIMEOUT(4)) u_fast (
        .clk(clk), .reset(reset), .start(f_start), .abort(1'b0), .continuous(f_cont),
        .err_clr(1'b0), .bus(fbus), .busy(f_busy), .err_timeout(f_err), .frame_cnt(f_frame_cnt)
    );
    assign fbus.blk_ready = 1'b1;
    assign fbus.enc_done  = 1'b1;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && ((32'(bus.cap_en) + 32'(bus.blk_valid) + 32'(bus.shift_en)) > 1 ||
                       (32'(fbus.cap_en) + 32'(fbus.blk_valid) + 32'(fbus.shift_en)) > 1))
            viol++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic to_enc(input string tag);
        int n = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (bus.blk_valid !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.blk_valid), 1);
        bus.blk_ready = 1'b1;
        tick();
        bus.blk_ready = 1'b0;
    endtask

    initial begin
        int n, v, bad;
        bus.blk_ready = 1'b0;
        bus.enc_done  = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_cap_en", 32'(bus.cap_en), 0);
        check("rst_cap_idx", 32'(bus.cap_idx), 0);
        check("rst_blk_valid", 32'(bus.blk_valid), 0);
        check("rst_shift_en", 32'(bus.shift_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err_timeout), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", 32'(busy), 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_wait", 32'(busy), 1);
        n = 0;
        while (bus.cap_en !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        check("first_cap", 32'(n), 289);
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            if (bus.cap_en !== 1'b1 || bus.cap_idx !== 7'(i)) bad++;
            tick();
        end
        check("cap_window", 32'(bad), 0);
        check("cap_end", 32'(bus.cap_en), 0);
        check("cap_idx_back", 32'(bus.cap_idx), 0);
        check("valid_rise", 32'(bus.blk_valid), 1);
        v = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.blk_valid === 1'b1) v++;
            tick();
        end
        bus.blk_ready = 1'b1;
        if (bus.blk_valid === 1'b1) v++;
        tick();
        bus.blk_ready = 1'b0;
        check("valid_len", 32'(v), 11);
        check("valid_drop", 32'(bus.blk_valid), 0);
        repeat (4) tick();
        bus.enc_done = 1'b1;
        tick();
        bus.enc_done = 1'b0;
        n = 0;
        while (bus.shift_en === 1'b1 && n < 300) begin
            n++;
            tick();
        end
        check("drain_len", 32'(n), 128);
        check("frame_cnt_1", 32'(frame_cnt), 1);
        check("idle_after", 32'(busy), 0);

        to_enc("reach_hs_tmo");
        repeat (63) tick();
        check("enc64_busy", 32'(busy), 1);
        check("enc64_noerr", 32'(err_timeout), 0);
        tick();
        check("tmo_err", 32'(err_timeout), 1);
        check("tmo_idle", 32'(busy), 0);
        check("tmo_frame", 32'(frame_cnt), 1);
        tick();
        check("err_sticky", 32'(err_timeout), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", 32'(err_timeout), 0);

        to_enc("reach_hs_done");
        repeat (63) tick();
        bus.enc_done = 1'b1;
        tick();
        bus.enc_done = 1'b0;
        check("done64_drain", 32'(bus.shift_en), 1);
        check("done64_noerr", 32'(err_timeout), 0);
        continuous = 1'b1;
        n = 0;
        while (bus.shift_en === 1'b1 && n < 300) begin
            n++;
            tick();
        end
        check("drain_len2", 32'(n), 128);
        check("frame_cnt_2", 32'(frame_cnt), 2);
        check("cont_busy", 32'(busy), 1);
        n = 0;
        while (bus.cap_en !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        check("restart_gap", 32'(n), 289);
        continuous = 1'b0;
        n = 0;
        while (bus.cap_idx !== 7'd50 && n < 200) begin
            tick();
            n++;
        end
        check("reach_idx50", 32'(bus.cap_idx), 50);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_cap_en", 32'(bus.cap_en), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_frame", 32'(frame_cnt), 2);

        to_enc("reach_hs_rst");
        bus.enc_done = 1'b1;
        tick();
        bus.enc_done = 1'b0;
        check("drain_mid", 32'(bus.shift_en), 1);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        check("mrst_shift_en", 32'(bus.shift_en), 0);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_frame", 32'(frame_cnt), 0);
        check("mrst_cap_idx", 32'(bus.cap_idx), 0);
        reset = 1'b0;
        tick();

        f_cont  = 1'b1;
        f_start = 1'b1;
        tick();
        f_start = 1'b0;
        n = 0;
        while (fbus.shift_en !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        while (fbus.shift_en === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        n = 0;
        while (fbus.cap_en !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("fast_gap", 32'(n), 2);
        n = 0;
        while (f_frame_cnt !== 8'd255 && n < 8000) begin
            tick();
            n++;
        end
        check("fast_255", 32'(f_frame_cnt), 255);
        n = 0;
        while (f_frame_cnt === 8'd255 && n < 100) begin
            tick();
            n++;
        end
        check("fast_wrap", 32'(f_frame_cnt), 0);
        f_cont = 1'b0;
        check("mutex", 32'(viol), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
